// File: rtl/ula_io_pkg.sv
// Shared constants and types for the ULA CPU-side I/O port block.
// Holds the ULAplus port addresses, the palette-select byte layout and the 0xFE read formatter.
package ula_io_pkg;

  localparam logic [15:0] PORT_PAL_SEL = 16'hBF3B;
  localparam logic [15:0] PORT_PAL_DAT = 16'hFF3B;

  typedef enum logic [1:0] {
    GRP_PALETTE = 2'b00,
    GRP_MODE    = 2'b01,
    GRP_RSVD2   = 2'b10,
    GRP_RSVD3   = 2'b11
  } pal_grp_e;

  typedef struct packed {
    pal_grp_e   grp;
    logic [5:0] idx;
  } pal_sel_t;

  // Port 0xFE read: bits 7 and 5 float high on the real bus.
  function automatic logic [7:0] fe_read(input logic ear, input logic [4:0] keys);
    return {1'b1, ear, 1'b1, keys};
  endfunction

endpackage

// File: rtl/ula_palette.sv
// ULAplus 64x8 palette: one CPU write port, a combinational CPU read
// and a registered, read-first video read.
module ula_palette
  import ula_io_pkg::*;
(
  input  logic       clk_cpu,
  input  logic       nreset,
  input  logic       i_we,
  input  logic [5:0] i_cpu_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_cpu_rdata,
  input  logic [5:0] i_vid_addr,
  output logic [7:0] o_vid_rdata
);

  logic [7:0] r_mem [0:63];
  logic [7:0] r_vid_rdata;

  // NOTE: the RAM array is deliberately left out of reset so it maps onto plain memory; contents are undefined until written.
  always_ff @(posedge clk_cpu) begin
    if (i_we) r_mem[i_cpu_addr] <= i_wdata;
  end

  // NOTE: non-blocking assignment makes the video port sample the pre-write entry, giving read-first behaviour on a collision.
  always_ff @(posedge clk_cpu or negedge nreset) begin
    if (!nreset) r_vid_rdata <= '0;
    else         r_vid_rdata <= r_mem[i_vid_addr];
  end

  assign o_cpu_rdata = r_mem[i_cpu_addr];
  assign o_vid_rdata = r_vid_rdata;

endmodule

// File: rtl/ula_io_ports.sv
// Spectrum ULA CPU-side I/O: port 0xFE latches and readback, EAR synchroniser,
// speaker output, beeper activity divider and optional ULAplus palette ports.
module ula_io_ports
  import ula_io_pkg::*;
#(
  parameter int BORDER_W    = 3,
  parameter int BLINK_DIV_W = 7,
  parameter int PALETTE_EN  = 1,
  parameter int EAR_SYNC    = 2
) (
  input  logic                clk_cpu,
  input  logic                nreset,
  input  logic [15:0]         A,
  input  logic [7:0]          D,
  input  logic                io_we,
  input  logic [4:0]          key_row,
  input  logic                ear_in,
  input  logic                tape_sound,
  output logic [7:0]          ula_data,
  output logic [BORDER_W-1:0] border,
  output logic                aud_out,
  output logic                mic_out,
  output logic                beeper,
  output logic                pal_mode,
  input  logic [5:0]          pal_rd_addr,
  output logic [7:0]          pal_rd_data
);

  logic [EAR_SYNC-1:0]    r_ear_sync;
  logic [BORDER_W-1:0]    r_border;
  logic [BORDER_W-1:0]    w_border_d;
  logic                   r_ear_lat, r_mic, r_aud;
  logic                   r_beep, r_beep_d, r_beeper;
  logic [BLINK_DIV_W-1:0] r_cnt;
  logic                   w_ear_s, w_fe_we, w_beep, w_beep_rise;
  logic [7:0]             w_sel_byte, w_pal_dat_byte, w_pal_vid;
  logic                   w_pal_mode;

  assign w_ear_s     = r_ear_sync[EAR_SYNC-1];
  assign w_fe_we     = io_we & ~A[0];
  assign w_beep      = w_ear_s ^ r_ear_lat ^ r_mic;
  assign w_beep_rise = r_beep & ~r_beep_d;

  generate
    if (BORDER_W == 4) begin : g_border4
      assign w_border_d = {D[5], D[2:0]};
    end else begin : g_border3
      assign w_border_d = D[2:0];
    end
  endgenerate

  // The beep edge is found with clk_cpu-sampled copies so nothing is clocked from data.
  always_ff @(posedge clk_cpu or negedge nreset) begin
    if (!nreset) begin
      r_ear_sync <= '0;
      r_border   <= '0;
      r_ear_lat  <= 1'b0;
      r_mic      <= 1'b0;
      r_aud      <= 1'b0;
      r_beep     <= 1'b0;
      r_beep_d   <= 1'b0;
      r_beeper   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_ear_sync <= {r_ear_sync[EAR_SYNC-2:0], ear_in};
      r_aud      <= (tape_sound & ~w_ear_s) ^ r_ear_lat;
      r_beep     <= w_beep;
      r_beep_d   <= r_beep;
      if (w_beep_rise) begin
        r_cnt <= r_cnt - BLINK_DIV_W'(1);
        if (r_cnt == '0) r_beeper <= ~r_beeper;
      end
      if (w_fe_we) begin
        r_border  <= w_border_d;
        r_ear_lat <= D[4];
        r_mic     <= D[3];
      end
    end
  end

  generate
    if (PALETTE_EN != 0) begin : g_pal
      pal_sel_t   r_sel;
      logic       r_pal_mode;
      logic       w_sel_we, w_dat_we, w_ram_we;
      logic [7:0] w_ram_cpu;

      assign w_sel_we = io_we && (A == PORT_PAL_SEL);
      assign w_dat_we = io_we && (A == PORT_PAL_DAT);
      assign w_ram_we = w_dat_we && (r_sel.grp == GRP_PALETTE);

      always_ff @(posedge clk_cpu or negedge nreset) begin
        if (!nreset) begin
          r_sel      <= '0;
          r_pal_mode <= 1'b0;
        end else begin
          if (w_sel_we) r_sel <= pal_sel_t'(D);
          if (w_dat_we && (r_sel.grp == GRP_MODE)) r_pal_mode <= D[0];
        end
      end

      ula_palette u_palette (
        .clk_cpu     (clk_cpu),
        .nreset      (nreset),
        .i_we        (w_ram_we),
        .i_cpu_addr  (r_sel.idx),
        .i_wdata     (D),
        .o_cpu_rdata (w_ram_cpu),
        .i_vid_addr  (pal_rd_addr),
        .o_vid_rdata (w_pal_vid)
      );

      // NOTE: every always_comb output is given a default first so no path can infer a latch.
      always_comb begin
        w_pal_dat_byte = 8'hFF;
        case (r_sel.grp)
          GRP_PALETTE: w_pal_dat_byte = w_ram_cpu;
          GRP_MODE:    w_pal_dat_byte = {7'b0, r_pal_mode};
          default:     ;
        endcase
      end

      assign w_sel_byte = r_sel;
      assign w_pal_mode = r_pal_mode;
    end else begin : g_no_pal
      assign w_sel_byte     = 8'hFF;
      assign w_pal_dat_byte = 8'hFF;
      assign w_pal_vid      = '0;
      assign w_pal_mode     = 1'b0;
    end
  endgenerate

  // ULAplus ports sit at odd addresses so they can never alias port 0xFE.
  always_comb begin
    ula_data = 8'hFF;
    if (!A[0])                                      ula_data = fe_read(w_ear_s, key_row);
    else if ((PALETTE_EN != 0) && (A == PORT_PAL_SEL)) ula_data = w_sel_byte;
    else if ((PALETTE_EN != 0) && (A == PORT_PAL_DAT)) ula_data = w_pal_dat_byte;
  end

  assign border      = r_border;
  assign aud_out     = r_aud;
  assign mic_out     = r_mic;
  assign beeper      = r_beeper;
  assign pal_mode    = w_pal_mode;
  assign pal_rd_data = w_pal_vid;

endmodule

// File: tb/tb_ula_io_ports.sv
// Self-checking bench for ula_io_ports: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_ula_io_ports;

  localparam int BW = 4;
  localparam int DW = 3;
  localparam int ES = 2;

  logic          clk_cpu = 1'b0;
  logic          nreset  = 1'b0;
  logic [15:0]   A = 16'h0000;
  logic [7:0]    D = 8'h00;
  logic          io_we = 1'b0;
  logic [4:0]    key_row = 5'h1F;
  logic          ear_in = 1'b0;
  logic          tape_sound = 1'b0;
  logic [5:0]    pal_rd_addr = 6'd0;
  logic [7:0]    ula_data;
  logic [BW-1:0] border;
  logic          aud_out, mic_out, beeper, pal_mode;
  logic [7:0]    pal_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  ula_io_ports #(
    .BORDER_W(BW), .BLINK_DIV_W(DW), .PALETTE_EN(1), .EAR_SYNC(ES)
  ) dut (
    .clk_cpu(clk_cpu), .nreset(nreset), .A(A), .D(D), .io_we(io_we),
    .key_row(key_row), .ear_in(ear_in), .tape_sound(tape_sound),
    .ula_data(ula_data), .border(border), .aud_out(aud_out), .mic_out(mic_out),
    .beeper(beeper), .pal_mode(pal_mode), .pal_rd_addr(pal_rd_addr),
    .pal_rd_data(pal_rd_data)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Behavioural model state
  logic [3:0] m_border;
  bit         m_ear_lat, m_mic, m_aud, m_beeper, m_pal_mode;
  logic [7:0] m_sel;
  logic [7:0] m_pal [64];
  bit         m_pal_ok [64];
  logic [7:0] m_pal_rd;
  bit         m_pal_rd_ok;
  bit         m_ear_q [$];
  bit         m_b1, m_b2;
  int         m_beep_edges;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_border = '0; m_ear_lat = 0; m_mic = 0; m_aud = 0; m_beeper = 0;
    m_pal_mode = 0; m_sel = '0; m_pal_rd = '0; m_pal_rd_ok = 1;
    m_b1 = 0; m_b2 = 0; m_beep_edges = 0;
    m_ear_q = {};
    repeat (ES) m_ear_q.push_back(1'b0);
  endfunction

  // Advance the model by one clk_cpu edge using the inputs present before it.
  function automatic void model_step();
    bit ear_s = m_ear_q[0];
    bit beep  = ear_s ^ m_ear_lat ^ m_mic;
    m_aud = (tape_sound & ~ear_s) ^ m_ear_lat;
    if (m_b1 && !m_b2) begin
      m_beep_edges++;
      if ((m_beep_edges - 1) % (1 << DW) == 0) m_beeper = ~m_beeper;
    end
    m_b2 = m_b1;
    m_b1 = beep;
    m_pal_rd    = m_pal[pal_rd_addr];
    m_pal_rd_ok = m_pal_ok[pal_rd_addr];
    if (io_we) begin
      if (!A[0]) begin
        m_border  = {D[5], D[2:0]};
        m_ear_lat = D[4];
        m_mic     = D[3];
      end else if (A == 16'hBF3B) begin
        m_sel = D;
      end else if (A == 16'hFF3B) begin
        if (m_sel[7:6] == 2'b00) begin
          m_pal[m_sel[5:0]]    = D;
          m_pal_ok[m_sel[5:0]] = 1;
        end else if (m_sel[7:6] == 2'b01) begin
          m_pal_mode = D[0];
        end
      end
    end
    m_ear_q.push_back(ear_in);
    void'(m_ear_q.pop_front());
  endfunction

  // Returns {known, expected ula_data} for the current address.
  function automatic logic [8:0] model_read();
    if (!A[0]) return {1'b1, 1'b1, m_ear_q[0], 1'b1, key_row};
    if (A == 16'hBF3B) return {1'b1, m_sel};
    if (A == 16'hFF3B) begin
      case (m_sel[7:6])
        2'b00:   return {m_pal_ok[m_sel[5:0]], m_pal[m_sel[5:0]]};
        2'b01:   return {1'b1, 7'b0, m_pal_mode};
        default: return {1'b1, 8'hFF};
      endcase
    end
    return {1'b1, 8'hFF};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic check_all();
    logic [8:0] r;
    check("border", 16'(border), 16'(m_border));
    check("mic_out", 16'(mic_out), 16'(m_mic));
    check("aud_out", 16'(aud_out), 16'(m_aud));
    check("beeper", 16'(beeper), 16'(m_beeper));
    check("pal_mode", 16'(pal_mode), 16'(m_pal_mode));
    if (m_pal_rd_ok) check("pal_rd_data", 16'(pal_rd_data), 16'(m_pal_rd));
    r = model_read();
    if (r[8]) check("ula_data", 16'(ula_data), 16'(r[7:0]));
  endtask

  // Asserts reset between clock edges; optionally with a port write pending.
  task automatic do_reset(input bit mid_write);
    ear_in = 1'b0; key_row = 5'h1F; A = 16'h00FE;
    if (mid_write) begin D = 8'hFF; io_we = 1'b1; end
    #2 nreset = 1'b0;
    model_reset();
    #1;
    check("rst_border", 16'(border), 16'h0);
    check("rst_mic", 16'(mic_out), 16'h0);
    check("rst_aud", 16'(aud_out), 16'h0);
    check("rst_beeper", 16'(beeper), 16'h0);
    check("rst_pal_mode", 16'(pal_mode), 16'h0);
    check("rst_pal_rd", 16'(pal_rd_data), 16'h0);
    check("rst_ula_fe", 16'(ula_data), 16'h00BF);
    @(posedge clk_cpu);
    #1;
    check("rst_write_lost", 16'(border), 16'h0);
    io_we = 1'b0;
    @(negedge clk_cpu);
    nreset = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          we;
    logic [4:0]  key;
    logic [3:0]  e_border;
    bit          e_mic;
    bit          e_aud;
    bit          e_pmode;
    logic [7:0]  e_ula;
  } vec_t;

  vec_t vt [11];

  initial begin
    int toggles;
    bit prev_led;

    for (int i = 0; i < 64; i++) m_pal_ok[i] = 0;

    vt[0]  = '{16'h00FE, 8'h17, 1'b1, 5'h1F, 4'h7, 1'b0, 1'b0, 1'b0, 8'hBF};
    vt[1]  = '{16'h00FE, 8'h20, 1'b1, 5'h0A, 4'h8, 1'b0, 1'b1, 1'b0, 8'hAA};
    vt[2]  = '{16'h00FE, 8'h0F, 1'b1, 5'h00, 4'h7, 1'b1, 1'b0, 1'b0, 8'hA0};
    vt[3]  = '{16'hBF3B, 8'h05, 1'b1, 5'h00, 4'h7, 1'b1, 1'b0, 1'b0, 8'h05};
    vt[4]  = '{16'hFF3B, 8'hA5, 1'b1, 5'h00, 4'h7, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[5]  = '{16'hBF3B, 8'h40, 1'b1, 5'h00, 4'h7, 1'b1, 1'b0, 1'b0, 8'h40};
    vt[6]  = '{16'hFF3B, 8'h01, 1'b1, 5'h00, 4'h7, 1'b1, 1'b0, 1'b1, 8'h01};
    vt[7]  = '{16'hBF3B, 8'hC0, 1'b1, 5'h00, 4'h7, 1'b1, 1'b0, 1'b1, 8'hC0};
    vt[8]  = '{16'hFF3B, 8'h77, 1'b1, 5'h00, 4'h7, 1'b1, 1'b0, 1'b1, 8'hFF};
    vt[9]  = '{16'h1234, 8'h00, 1'b0, 5'h15, 4'h7, 1'b1, 1'b0, 1'b1, 8'hB5};
    vt[10] = '{16'h1235, 8'h00, 1'b0, 5'h15, 4'h7, 1'b1, 1'b0, 1'b1, 8'hFF};

    do_reset(1'b0);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      A = vt[i].a; D = vt[i].d; io_we = vt[i].we; key_row = vt[i].key;
      tick();
      io_we = 1'b0;
      check($sformatf("vec%0d_border", i), 16'(border), 16'(vt[i].e_border));
      check($sformatf("vec%0d_mic", i), 16'(mic_out), 16'(vt[i].e_mic));
      check($sformatf("vec%0d_aud", i), 16'(aud_out), 16'(vt[i].e_aud));
      check($sformatf("vec%0d_pal_mode", i), 16'(pal_mode), 16'(vt[i].e_pmode));
      check($sformatf("vec%0d_ula", i), 16'(ula_data), 16'(vt[i].e_ula));
    end

    // Read-first collision on palette index 5
    A = 16'hBF3B; D = 8'h05; io_we = 1'b1; pal_rd_addr = 6'd5;
    tick();
    A = 16'hFF3B; D = 8'h3C; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    check("collide_old", 16'(pal_rd_data), 16'h00A5);
    check("collide_cpu_new", 16'(ula_data), 16'h003C);
    tick();
    check("collide_new", 16'(pal_rd_data), 16'h003C);

    // EAR path latency with tape monitoring
    A = 16'h00FE; D = 8'h00; io_we = 1'b1;
    tick();
    io_we = 1'b0; tape_sound = 1'b1; ear_in = 1'b1; key_row = 5'h1F;
    repeat (4) tick();
    check("ear_high_aud", 16'(aud_out), 16'h0);
    check("ear_high_bit6", 16'(ula_data[6]), 16'h1);
    ear_in = 1'b0;
    for (int i = 1; i <= ES + 1; i++) begin
      tick();
      check($sformatf("ear_lat%0d_aud", i), 16'(aud_out), 16'((i == ES + 1) ? 1 : 0));
      check($sformatf("ear_lat%0d_bit6", i), 16'(ula_data[6]), 16'((i >= ES) ? 0 : 1));
    end
    ear_in = 1'b1;
    tick();
    tape_sound = 1'b0; ear_in = 1'b0;
    repeat (ES + 1) tick();

    // Reset mid-write, then the blink divider
    do_reset(1'b1);
    toggles = 0;
    prev_led = beeper;
    for (int e = 0; e < 16; e++) begin
      for (int s = 0; s < 4; s++) begin
        A = 16'h00FE; D = (s == 0) ? 8'h08 : 8'h00; io_we = (s == 0 || s == 2);
        tick();
        io_we = 1'b0;
        if (beeper !== prev_led) toggles++;
        prev_led = beeper;
      end
      if (e == 0) check("blink_first_edge", 16'(beeper), 16'h1);
    end
    check("blink_toggles", 16'(toggles), 16'd2);
    check("blink_final", 16'(beeper), 16'h0);
    check_all();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)      A = 16'($urandom) & 16'hFFFE;
      else if (r < 6) A = 16'hBF3B;
      else if (r < 9) A = 16'hFF3B;
      else            A = 16'($urandom);
      D           = 8'($urandom);
      io_we       = 1'($urandom_range(0, 1));
      key_row     = 5'($urandom);
      pal_rd_addr = 6'($urandom);
      if ($urandom_range(0, 5) == 0) ear_in = ~ear_in;
      if ($urandom_range(0, 15) == 0) tape_sound = ~tape_sound;
      tick();
      io_we = 1'b0;
      check_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_io_ports.md
# ula_io_ports

Parametrised CPU-side I/O port block for the Spectrum ULA, in the `clk_cpu` domain between the Z80 bus and the video, keyboard and audio paths. It implements port 0xFE with border, EAR/MIC, keyboard and EAR readback. It also provides a synchronised EAR input and a clock-domain-safe beeper activity LED divider. An optional ULAplus 64-entry palette is decoded at 0xBF3B/0xFF3B, with a registered read port for the video block.

## Interface
- `BORDER_W`, 3: border index width, 3 or 4; bit 3 is taken from D[5].
- `BLINK_DIV_W`, 7: width of the beeper activity divider.
- `PALETTE_EN`, 1: 1 instantiates ULAplus ports and palette; 0 ties palette outputs to 0 and removes decode.
- `EAR_SYNC`, 2: number of EAR input synchroniser stages, minimum 2.

Ports:
- `clk_cpu`, in, 1: CPU clock. The single clock of the block.
- `nreset`, in, 1: reset, asynchronous and active-low.
- `A`, in, 16: CPU address bus.
- `D`, in, 8: CPU write data.
- `io_we`, in, 1: I/O write strobe. The CPU wrapper holds it high for exactly one cycle per OUT.
- `key_row`, in, 5: active-low keyboard row data from zx_keyboard.
- `ear_in`, in, 1: raw tape/EAR input, asynchronous.
- `tape_sound`, in, 1: enables monitoring of the tape input on `aud_out`.
- `ula_data`, out, 8: CPU read data, combinational.
- `border`, out, BORDER_W: border colour index.
- `aud_out`, out, 1: speaker output, registered.
- `mic_out`, out, 1: MIC latch (D[3]).
- `beeper`, out, 1: activity LED.
- `pal_mode`, out, 1: ULAplus palette enable.
- `pal_rd_addr`, in, 6: palette index requested by video.
- `pal_rd_data`, out, 8: palette entry, 1-cycle latency.

## Operation
- **Port 0xFE** is decoded as A[0]==0, with no other address bits.
  - On write: `border`<=D[2:0] (plus D[5] as bit 3 when BORDER_W=4), `ear_lat`<=D[4], `mic_out`<=D[3].
  - On read: `ula_data`={1, ear_s, 1, key_row}.
  - `ear_s` is the last stage of the EAR synchroniser.
- **Audio:** each cycle, `aud_out`<=(tape_sound & ~ear_s) ^ ear_lat.
- **Beep activity:**
  - `beep`=ear_s ^ ear_lat ^ mic_out is registered once more, then a rising edge is detected in `clk_cpu`. Nothing is clocked from data.
  - On each rising edge, `cnt`<=cnt-1. If cnt==0 at that edge, `beeper` toggles (wrap from 0 to all-ones).
  - One LED toggle therefore occurs per 2^BLINK_DIV_W beep edges.
- **ULAplus** (PALETTE_EN=1), using a full 16-bit compare:
  - Write 0xBF3B: `sel`<=D (group=D[7:6], index=D[5:0]).
  - Write 0xFF3B, group 00: `palette[index]`<=D.
  - Write 0xFF3B, group 01: `pal_mode`<=D[0].
  - Write 0xFF3B, other groups: ignored.
  - Read 0xFF3B, group 00: returns `palette[index]`.
  - Read 0xFF3B, group 01: returns {7'b0, pal_mode}.
  - Read 0xFF3B, other groups: returns 0xFF.
  - Read 0xBF3B: returns `sel`.
- **Read priority:**
  - 0xBF3B and 0xFF3B have A[0]=1, so they cannot alias port 0xFE.
  - Every other address returns 0xFF.
- **Video read:** `pal_rd_data`<=palette[pal_rd_addr] on every clock.
  - A simultaneous CPU write to the same index is read-first: video gets the old value, and the new value appears on the following cycle.

## Timing
- **Reset values:** all outputs and state clear to 0 on `nreset` low, asynchronously. This covers border, ear_lat, mic_out, aud_out, beeper, cnt, sel, pal_mode, pal_rd_data and the synchroniser/edge registers.
- **Palette RAM** is not reset; its contents are undefined until written.
- **Port writes** take effect on the `clk_cpu` edge where `io_we`=1. Outputs change the same edge.
- **Audio latency:** `aud_out` reflects a port write 1 cycle later, and an `ear_in` change EAR_SYNC+1 cycles later.
- **Reads** are combinational from current state. A read in the same cycle as a write returns the pre-write value.
- **Reset mid-write:** the write is lost and no partial update occurs.
- **Counter wrap:** `cnt` wraps modulo 2^BLINK_DIV_W. There is no saturation.

## Structure
- **Package `ula_io_pkg`:**
  - Port constants: PORT_PAL_SEL=16'hBF3B, PORT_PAL_DAT=16'hFF3B.
  - Group codes: GRP_PALETTE=2'b00, GRP_MODE=2'b01.
- **Sub-module `ula_palette`:** 64x8 array with one write port, one combinational CPU read and one registered video read.
- The top level holds the port decode, latches, synchroniser and blink divider.

## Test plan
- **Reset:** assert `nreset` low mid-simulation -> all outputs 0; `ula_data` at A=0x00FE with key_row=5'h1F, ear=0 reads 0xBF.
- **Border and audio:**
  - OUT 0xFE, D=0x17 -> border=3'h7, mic_out=0, aud_out=1 one cycle later.
  - With BORDER_W=4, D=0x20 -> border=4'h8.
- **EAR path:**
  - tape_sound=1, ear_lat=0, ear_in pulsed 0 -> aud_out=1 after EAR_SYNC+1 cycles.
  - Read 0xFE gives bit6=0 while ear_s=0.
- **Blink divider:** BLINK_DIV_W=3, 16 beep rising edges -> beeper toggles exactly twice, first on edge 1 (cnt 0 -> 7).
- **Palette:**
  - Write sel=0x05, data=0xA5, then read 0xFF3B -> 0xA5.
  - sel=0x40, write 0x01 -> pal_mode=1.
  - Read 0xBF3B -> 0x40.
- **Read-first collision:** video pal_rd_addr=5 in the same cycle as a CPU write of 0x3C to index 5 -> pal_rd_data shows the old 0xA5, then 0x3C next cycle.
